// File: rtl/seg7_history_display.sv
// seg7_history_display
//   Captures the 4-bit sequencer output on every load strobe into a shift
//   history of NUM_DIGITS entries (newest at digit 0) and time-multiplexes
//   that history onto a common-anode 7-segment display as hex glyphs.
//
// Parameters
//   NUM_DIGITS  : display digits and history depth (2..8)
//   REFRESH_DIV : clock cycles each digit stays enabled (>=2)
//
// Ports
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   load  : capture strobe (shared with the upstream sequencer advance)
//   value : hex value captured when load=1
//   seg   : segment drive {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit enables, active-low one-hot, registered
//   dp    : decimal point, active-low
//
// Optional build macro
//   SEG7_NEWEST_DP_EN : when defined, dp lights (0) while digit 0 shows a
//                       valid newest value; when undefined dp is tied to 1.
module seg7_history_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [3:0]            value,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]            r_hist [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_valid;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tc;
  logic [3:0]            w_cur_hist;
  logic                  w_cur_valid;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  // Hex glyph, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_tc        = (r_cnt == CNT_LAST);
  assign w_cur_hist  = r_hist[r_idx];
  assign w_cur_valid = r_valid[r_idx];
  assign w_seg_next  = w_cur_valid ? hex_glyph(w_cur_hist) : 7'h7F;
  assign w_an_next   = ~(NUM_DIGITS'(1) << r_idx);

  // History shift register: newest at index 0, oldest falls off the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_hist[i] <= 4'h0;
      end
      r_valid <= '0;
    end else if (load) begin
      r_hist[0] <= value;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
      r_valid <= {r_valid[NUM_DIGITS-2:0], 1'b1};
    end
  end

  // Refresh divider and scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output stage: pins reflect the pre-edge idx/history, one cycle behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

`ifdef SEG7_NEWEST_DP_EN
  logic r_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp <= 1'b1;
    end else begin
      r_dp <= ~((r_idx == '0) && r_valid[0]);
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_history_display.sv
module tb_seg7_history_display;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk;
  logic         rst;
  logic         load;
  logic [3:0]   value;
  logic [6:0]   seg;
  logic [N-1:0] an;
  logic         dp;

  seg7_history_display #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .value(value),
    .seg  (seg),
    .an   (an),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         dp;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hist_q[$];   // newest first
  int         edges;       // rising edges since reset release
  int         n_tests;
  int         n_fail;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Expected pins after the next edge, from the state reached after `edges` edges
  function automatic exp_t predict();
    exp_t e;
    int   idx;
    idx   = (edges / DIV) % N;
    e.an  = ~(N'(1) << idx);
    e.seg = (idx < hist_q.size()) ? glyph_tab[hist_q[idx]] : 7'h7F;
`ifdef SEG7_NEWEST_DP_EN
    e.dp  = (idx == 0 && hist_q.size() > 0) ? 1'b0 : 1'b1;
`else
    e.dp  = 1'b1;
`endif
    return e;
  endfunction

  // Called at a falling edge: queue the expectation, drive inputs, advance model
  task automatic step(input logic ld, input logic [3:0] v);
    exp_q.push_back(predict());
    load  = ld;
    value = v;
    if (ld) begin
      hist_q.push_front(v);
      if (hist_q.size() > N) void'(hist_q.pop_back());
    end
    edges++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(15, 0));
  endtask

  task automatic do_reset();
    load  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_an",  32'(an),  32'(4'hF));
    check("rst_seg", 32'(seg), 32'(7'h7F));
    check("rst_dp",  32'(dp),  32'(1'b1));
    repeat (2) @(negedge clk);
    check("rst_hold_an",  32'(an),  32'(4'hF));
    check("rst_hold_seg", 32'(seg), 32'(7'h7F));
    rst = 1'b0;
    hist_q.delete();
    edges = 0;
  endtask

  // Monitor: every output edge, pop the oldest expectation and compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("an",  32'(an),  32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("dp",  32'(dp),  32'(e.dp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    edges   = 0;
    rst     = 1'b0;
    load    = 1'b0;
    value   = 4'h0;
    @(negedge clk);
    do_reset();

    // Scan with no captures: all blank
    idle(20);

    // Single capture of 4
    step(1'b1, 4'h4);
    idle(18);

    // History and overflow: 4 falls off
    step(1'b1, 4'h4);
    step(1'b1, 4'h8);
    step(1'b1, 4'hC);
    step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    idle(20);

    // Capture coincident with the refresh terminal count
    while (edges % DIV != DIV - 1) step(1'b0, 4'h0);
    step(1'b1, 4'hA);
    idle(18);

    // Newest-digit marker case
    step(1'b1, 4'hF);
    idle(18);

    // Mid-scan reset clears history
    idle(2);
    do_reset();
    idle(20);

    // Randomized traffic, including bursts of held load
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(2, 0) == 0), $urandom_range(15, 0));
      if (i == 150) begin
        do_reset();
      end
    end
    idle(4);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
